fp_addsub_arbiter: RTL
======================

# fp_addsub_arbiter

Round-robin arbiter and sequencer that shares one 3-cycle Fp add datapath (`multi_cycle_adder`, latency 3) and one 3-cycle Fp subtract datapath (`multi_cycle_subtractor`, latency 3) among `N_REQ` requesters. It sits between the Fp arithmetic units of the BN254 pairing core and the shared add/sub resource. It accepts at most one operation per cycle and tracks the owner and opcode of each in-flight operation through a tag pipeline. It returns each result to its issuer as a single-cycle response.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(N_REQ)`: requester index width. Derived; do not override.
- `clk` in 1: clock.
- `rst_n` in 1: reset; one clock, asynchronous, active-low.
- `req_valid` in `N_REQ`: per-requester operation request.
- `req_ready` out `N_REQ`: one-hot grant; transfer when `req_valid[i] & req_ready[i]`.
- `req_sub` in `N_REQ`: 1 = X−Y, 0 = X+Y.
- `req_x`, `req_y` in `N_REQ` × `uint_fp_t`: operands (272 bits each).
- `rsp_valid` out `N_REQ`: one-hot, single-cycle result strobe.
- `rsp_z` out `uint_fp_t`: result, shared by all requesters.
- `rsp_carry` out 1: add carry-out, or subtract "no borrow" (1 ⇔ X ≥ Y).
- `busy` out 1: at least one operation in flight.

## Operation
- **Arbitration**
  - `req_ready` is combinational from `req_valid` and the priority pointer `ptr`.
  - The grant goes to the first `i` with `req_valid[i]=1`, scanning `ptr, ptr+1, …` modulo `N_REQ`.
  - At most one bit of `req_ready` is set. `req_ready` is all-zero when no requester is valid.
- **Pointer update**
  - On a transfer from requester `g`, `ptr <= (g+1) mod N_REQ`.
  - With no transfer, `ptr` holds.
  - Wrap: a grant to `N_REQ-1` sets `ptr` to 0.
- **Requester rules**
  - Once `req_valid[i]` is raised, the requester holds it, along with `req_sub[i]`, `req_x[i]` and `req_y[i]`, stable until the transfer.
  - A requester may issue back-to-back operations. It regains the grant only after every other valid requester has been served once.
- **Issue**
  - The granted operands are muxed combinationally into both datapaths every cycle.
  - With no grant, the mux selects requester 0. The result is discarded because the tag is invalid.
- **Tag pipeline**
  - 3 stages, each holding {v, id[ID_W], sub}.
  - Stage 0 loads {transfer, g, `req_sub[g]`}. Stages 1–2 shift.
- **Response**
  - Driven from the last tag stage: `rsp_valid[id] = v`.
  - `rsp_z`/`rsp_carry` come from the subtractor outputs when `sub=1`, and from the adder outputs otherwise.
  - `rsp_z` and `rsp_carry` are don't-care when `rsp_valid` is all-zero.
- **Arithmetic**
  - Add: {carry, Z} = X + Y, 273 bits.
  - Sub: {carry, Z} = X + ~Y + 1. Z = (X − Y) mod 2^272.
  - No modular reduction is done in this block.
- **busy** = OR of the tag-stage valid bits.
- **No output backpressure**: requesters must accept `rsp_valid` in the cycle it is asserted.

## Timing
- Transfer in cycle T → `rsp_valid[g]`, `rsp_z` and `rsp_carry` valid in cycle T+3 (three clock edges).
- Throughput: one operation per cycle. Transfers in consecutive cycles give responses in consecutive cycles, in issue order.
- **Reset values** (asynchronous on `rst_n` low):
  - `ptr`=0 and all tag valids=0.
  - `rsp_valid`=0 and `busy`=0.
  - `req_ready`=0 while `rst_n` is low, regardless of `req_valid`.
  - Datapath registers are not reset; `rsp_z` and `rsp_carry` are undefined after reset.
- **Reset mid-operation**: all in-flight operations are dropped and no response is produced for them. After release, the first grant scans from requester 0.
- **Simultaneous requests**: exactly one is granted per cycle. A loser keeps `req_valid` and is granted within `N_REQ-1` cycles.

## Configuration
- `FP_ADDSUB_ARB_STATS_EN` defined adds two outputs:
  - `stat_ops` (32b): counts transfers.
  - `stat_conflicts` (32b): counts cycles with ≥2 `req_valid` bits set.
  - Both saturate at 2^32−1 and reset to 0 on `rst_n`.
- `FP_ADDSUB_ARB_STATS_EN` undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- **Single add.** Req 1 issues X=5, Y=7, sub=0 at cycle T.
  - `req_ready`=4'b0010 at T.
  - `rsp_valid`=4'b0010, `rsp_z`=12, `rsp_carry`=0 at T+3 only.
- **Subtract with borrow.** Req 2 issues X=3, Y=5, sub=1.
  - `rsp_z`=2^272−2, `rsp_carry`=0.
  - Then X=5, Y=3 → `rsp_z`=2, `rsp_carry`=1.
- **Add overflow.** X=2^272−1, Y=1, sub=0 → `rsp_z`=0, `rsp_carry`=1.
- **Round-robin.** All 4 requesters hold `req_valid` for 8 cycles from reset.
  - Grants are 0,1,2,3,0,1,2,3.
  - Responses arrive in the same order, each 3 cycles after its grant, with no gaps.
- **Mixed ops back-to-back.** Req 0 issues add(1,1), then sub(1,1), then add(2,3) on consecutive cycles.
  - Consecutive responses: z=2/c=0, z=0/c=1, z=5/c=0.
- **Reset mid-flight.** Issue 2 ops, then assert `rst_n` low one cycle after the second.
  - No `rsp_valid` follows; `busy`=0 immediately.
  - After release, a new request from req 3 is granted and returns correctly.
  - With `FP_ADDSUB_ARB_STATS_EN` defined, `stat_ops` reads 0 after the reset.

Source files
------------

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: round-robin sharing of one 3-cycle Fp add and sub datapath.
// Define FP_ADDSUB_ARB_STATS_EN to add the stat_ops / stat_conflicts counters.
package fp_addsub_pkg;
  localparam int FP_W = 272;
  typedef logic [FP_W-1:0] uint_fp_t;
endpackage

module fp_addsub_arbiter
  import fp_addsub_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ-1:0]     req_sub,
  input  uint_fp_t [N_REQ-1:0] req_x,
  input  uint_fp_t [N_REQ-1:0] req_y,
  output logic [N_REQ-1:0]     rsp_valid,
  output uint_fp_t             rsp_z,
  output logic                 rsp_carry,
  output logic                 busy
`ifdef FP_ADDSUB_ARB_STATS_EN
  ,
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_conflicts
`endif
);

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
    logic            sub;
  } tag_t;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  logic            xfer;

  // Scan ptr, ptr+1, ... modulo N_REQ; first valid wins.
  always_comb begin
    logic [ID_W:0] s;
    gnt_any = 1'b0;
    gnt_id  = '0;
    s       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s = {1'b0, ptr} + (ID_W+1)'(k);
      if (s >= (ID_W+1)'(N_REQ))
        s = s - (ID_W+1)'(N_REQ);
      if (!gnt_any && req_valid[s[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = s[ID_W-1:0];
      end
    end
  end

  assign xfer = gnt_any & rst_n;

  always_comb begin
    req_ready = '0;
    if (xfer)
      req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (xfer)
      ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + ID_W'(1);
  end

  tag_t [2:0] tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= '0;
    end else begin
      tag[0] <= '{v: xfer, id: gnt_id, sub: req_sub[gnt_id]};
      tag[1] <= tag[0];
      tag[2] <= tag[1];
    end
  end

  uint_fp_t        x_q;
  uint_fp_t        y_q;
  logic [FP_W:0]   add_q1;
  logic [FP_W:0]   sub_q1;
  logic [FP_W:0]   add_q2;
  logic [FP_W:0]   sub_q2;

  // Operand mux idles on requester 0; the invalid tag discards its result.
  always_ff @(posedge clk) begin
    x_q    <= req_x[gnt_id];
    y_q    <= req_y[gnt_id];
    add_q1 <= {1'b0, x_q} + {1'b0, y_q};
    sub_q1 <= {1'b0, x_q} + {1'b0, ~y_q} + (FP_W+1)'(1);
    add_q2 <= add_q1;
    sub_q2 <= sub_q1;
  end

  always_comb begin
    rsp_valid = '0;
    if (tag[2].v)
      rsp_valid[tag[2].id] = 1'b1;
  end

  assign {rsp_carry, rsp_z} = tag[2].sub ? sub_q2 : add_q2;
  assign busy = tag[0].v | tag[1].v | tag[2].v;

`ifdef FP_ADDSUB_ARB_STATS_EN
  logic multi;

  assign multi = |(req_valid & (req_valid - N_REQ'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops       <= '0;
      stat_conflicts <= '0;
    end else begin
      if (xfer && stat_ops != '1)
        stat_ops <= stat_ops + 32'd1;
      if (multi && stat_conflicts != '1)
        stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule
